ifetcher_unit: RTL
==================

IFETCHER_UNIT -- requirements
Module: ifetcher_unit

Interface
REQ-001 SHALL have clock and reset: clk; reset rst, synchronous, active-high; plus rdy (input, 1: pipeline enable; when low, all state holds).
REQ-002 SHALL expose: clk  in  1  clock.
REQ-003 SHALL expose: rst  in  1  synchronous active-high reset.
REQ-004 SHALL expose: rdy  in  1  global enable.
REQ-005 SHALL expose: mc_req  out  1  word-fetch request to memory controller.
REQ-006 SHALL expose: mc_addr  out  32  fetch address, word aligned.
REQ-007 SHALL expose: mc_done  in  1  fetch complete, one-cycle pulse.
REQ-008 SHALL expose: mc_data  in  32  fetched word, valid with mc_done.
REQ-009 SHALL expose: is_stall  in  1  issue stage cannot accept (ROB/RS/LSB full).
REQ-010 SHALL expose: is_valid, is_ins, is_pc, is_pred, is_pred_pc  out  1/32/32/1/32  instruction to issue, its PC, predicted-taken flag, predicted next PC.
REQ-011 SHALL expose: rob_clear, rob_newpc  in  1/32  misprediction flush and restart PC.
REQ-012 SHALL expose: bp_upd, bp_pc, bp_taken  in  1/32/1  resolved-branch predictor update.

Function
REQ-013 SHALL hold a direct-mapped icache: 64 one-word lines, index pc[7:2], tag pc[17:8], valid bit per line.
REQ-014 SHALL implement FSM IDLE, MEM_WAIT. In IDLE with !is_stall: on hit, present the line next cycle (is_valid=1 for exactly one cycle) and advance pc; on miss, assert mc_req/mc_addr=pc and enter MEM_WAIT.
REQ-015 SHALL hold mc_req high and mc_addr stable in MEM_WAIT until mc_done; on mc_done, fill the line, present the word next cycle, advance pc, return to IDLE.
REQ-016 SHALL fetch nothing while is_stall=1; is_valid SHALL be 0 while stalled; an in-flight MEM_WAIT SHALL complete and fill but present only after is_stall drops (via the then-hitting line).
REQ-017 SHALL predict the next pc: JAL (opcode 1101111) -> taken, pc+immJ; B-type (1100011) -> taken per REQ-027, pc+immB; all else -> pc+4, is_pred=0.
REQ-018 SHALL drive is_pred_pc = predicted next pc; all address arithmetic SHALL be 32-bit modulo 2^32.
REQ-019 SHALL give rob_clear priority over every other event: pc<=rob_newpc, is_valid<=0 next cycle, FSM<=IDLE, mc_req<=0; mc_done coincident with or one cycle after rob_clear SHALL NOT fill the cache.
REQ-020 SHALL serve a hit on the line being filled in the same cycle as a miss fill (no stale read).
REQ-021 SHALL ignore all inputs except rst while rdy=0.

Reset
REQ-022 SHALL on rst set pc=0, FSM=IDLE, all cache valid bits=0, mc_req=0, mc_addr=0.
REQ-023 SHALL on rst drive is_valid=0, is_ins=0, is_pc=0, is_pred=0, is_pred_pc=0.
REQ-024 SHALL on rst initialise every predictor counter to 2'b01 (weakly not-taken) when compiled in.
REQ-025 SHALL treat rst mid-MEM_WAIT as a full abort; later mc_done ignored.

Configuration
REQ-026 SHALL recognise macro BRANCH_PREDICTOR_EN.
REQ-027 With BRANCH_PREDICTOR_EN: 64-entry 2-bit saturating BHT indexed pc[7:2]; taken when counter>=2; bp_upd increments (taken, saturate 3) or decrements (not taken, saturate 0) entry bp_pc[7:2].
REQ-028 Without BRANCH_PREDICTOR_EN: B-type always predicted not-taken (is_pred=0, pc+4); bp_* ignored; JAL still predicted taken.

Structure
REQ-029 SHALL take opcode constants, FSM state encodings, cache geometry (index/tag widths) from the shared defines package.
REQ-030 SHALL place the BHT in sub-module branch_predictor (read port by pc, update port by bp_*).

Verification
REQ-031 Reset, memory holds 0x00000013 at 0 -> one mc_req addr 0; mc_done -> next cycle is_valid=1, is_ins=0x00000013, is_pc=0, is_pred_pc=4.
REQ-032 Loop 0x0..0xC then JAL -12 at 0xC, second iteration -> no mc_req, is_valid each cycle, is_pc at 0xC has is_pred=1, is_pred_pc=0.
REQ-033 is_stall=1 for 5 cycles during hits -> is_valid=0, pc frozen; release -> resumes same pc.
REQ-034 rob_clear with rob_newpc=0x100 during MEM_WAIT, mc_done same cycle -> no fill, next mc_addr=0x100.
REQ-035 With macro: BEQ at 0x20, two bp_upd taken -> is_pred=1, is_pred_pc=0x20+immB; without macro -> is_pred=0, is_pred_pc=0x24.
REQ-036 rdy=0 for 3 cycles mid-MEM_WAIT -> mc_req held, no state change.

Source files
------------

// File: rtl/ifetcher_unit_pkg.sv
// Shared definitions for the instruction fetcher: opcodes, FSM encoding,
// icache geometry and immediate decoders.
package ifetcher_unit_pkg;

    localparam int IDX_W   = 6;
    localparam int TAG_W   = 10;
    localparam int LINES   = 1 << IDX_W;
    localparam int IDX_LSB = 2;
    localparam int TAG_LSB = IDX_LSB + IDX_W;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_MEM_WAIT = 1'b1
    } fetch_state_e;

    function automatic logic [31:0] imm_j(input logic [31:0] ins);
        return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ins);
        return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/ifetcher_unit_branch_predictor.sv
// 64-entry table of 2-bit saturating counters; read by fetch pc,
// trained by resolved branches. Counters reset to weakly not-taken.
module branch_predictor
    import ifetcher_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [1:0] bht_q [LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LINES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (en && upd) begin
            if (upd_taken && bht_q[upd_idx] != 2'b11) begin
                bht_q[upd_idx] <= bht_q[upd_idx] + 2'b01;
            end else if (!upd_taken && bht_q[upd_idx] != 2'b00) begin
                bht_q[upd_idx] <= bht_q[upd_idx] - 2'b01;
            end
        end
    end

    // Counter MSB set means value 2 or 3: predict taken.
    assign rd_taken = bht_q[rd_idx][1];

endmodule

// File: rtl/ifetcher_unit.sv
// Instruction fetcher with a 64-line direct-mapped icache and next-pc
// prediction; BHT-based branch prediction enabled by BRANCH_PREDICTOR_EN.
module ifetcher_unit
    import ifetcher_unit_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    output logic         mc_req,
    output logic [31:0]  mc_addr,
    input  logic         mc_done,
    input  logic [31:0]  mc_data,
    input  logic         is_stall,
    output logic         is_valid,
    output logic [31:0]  is_ins,
    output logic [31:0]  is_pc,
    output logic         is_pred,
    output logic [31:0]  is_pred_pc,
    input  logic         rob_clear,
    input  logic [31:0]  rob_newpc,
    input  logic         bp_upd,
    input  logic [31:0]  bp_pc,
    input  logic         bp_taken,
    output fetch_state_e dbg_state
);

    // Handshakes: mc_req stays high with mc_addr stable until a one-cycle
    // mc_done; is_valid is a one-cycle pulse, never raised while is_stall=1.
    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         mc_req_d, is_valid_d, is_pred_d, fill_en, present;
    logic [31:0]  mc_addr_d, is_ins_d, is_pc_d, is_pred_pc_d;

    logic [LINES-1:0] line_valid_q;
    logic [TAG_W-1:0] line_tag_q  [LINES];
    logic [31:0]      line_data_q [LINES];

    logic [IDX_W-1:0] pc_idx;
    logic [TAG_W-1:0] pc_tag;
    logic             hit, bht_taken, bp_rd_taken, pred_taken;
    logic [31:0]      fetch_word, pred_pc;
    logic             unused_bp;

    assign pc_idx     = pc_q[IDX_LSB +: IDX_W];
    assign pc_tag     = pc_q[TAG_LSB +: TAG_W];
    assign hit        = line_valid_q[pc_idx] && (line_tag_q[pc_idx] == pc_tag);
    // While a fill lands, the word comes straight from the memory bus.
    assign fetch_word = (state_q == S_MEM_WAIT) ? mc_data : line_data_q[pc_idx];
    assign dbg_state  = state_q;

`ifdef BRANCH_PREDICTOR_EN
    branch_predictor u_bp (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .rd_idx    (pc_idx),
        .rd_taken  (bp_rd_taken),
        .upd       (bp_upd),
        .upd_idx   (bp_pc[IDX_LSB +: IDX_W]),
        .upd_taken (bp_taken)
    );
    assign bht_taken = bp_rd_taken;
    assign unused_bp = ^{bp_pc[31:TAG_LSB], bp_pc[IDX_LSB-1:0]};
`else
    // Table is never trained and its prediction is discarded.
    branch_predictor u_bp (
        .clk       (clk),
        .rst       (rst),
        .en        (rdy),
        .rd_idx    (pc_idx),
        .rd_taken  (bp_rd_taken),
        .upd       (1'b0),
        .upd_idx   ({IDX_W{1'b0}}),
        .upd_taken (1'b0)
    );
    assign bht_taken = 1'b0;
    assign unused_bp = ^{bp_upd, bp_pc, bp_taken, bp_rd_taken};
`endif

    always_comb begin
        pred_taken = 1'b0;
        pred_pc    = pc_q + 32'd4;
        if (fetch_word[6:0] == OPC_JAL) begin
            pred_taken = 1'b1;
            pred_pc    = pc_q + imm_j(fetch_word);
        end else if (fetch_word[6:0] == OPC_BRANCH && bht_taken) begin
            pred_taken = 1'b1;
            pred_pc    = pc_q + imm_b(fetch_word);
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        mc_req_d     = mc_req;
        mc_addr_d    = mc_addr;
        is_valid_d   = 1'b0;
        is_ins_d     = is_ins;
        is_pc_d      = is_pc;
        is_pred_d    = is_pred;
        is_pred_pc_d = is_pred_pc;
        fill_en      = 1'b0;
        present      = 1'b0;
        if (rob_clear) begin
            pc_d     = rob_newpc;
            state_d  = S_IDLE;
            mc_req_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!is_stall) begin
                        if (hit) begin
                            present = 1'b1;
                        end else begin
                            mc_req_d  = 1'b1;
                            mc_addr_d = {pc_q[31:2], 2'b00};
                            state_d   = S_MEM_WAIT;
                        end
                    end
                end
                S_MEM_WAIT: begin
                    // A stalled fill still lands; the word is re-read as a hit later.
                    if (mc_done) begin
                        fill_en  = 1'b1;
                        mc_req_d = 1'b0;
                        state_d  = S_IDLE;
                        present  = !is_stall;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (present) begin
            is_valid_d   = 1'b1;
            is_ins_d     = fetch_word;
            is_pc_d      = pc_q;
            is_pred_d    = pred_taken;
            is_pred_pc_d = pred_pc;
            pc_d         = pred_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= 32'd0;
            mc_req       <= 1'b0;
            mc_addr      <= 32'd0;
            is_valid     <= 1'b0;
            is_ins       <= 32'd0;
            is_pc        <= 32'd0;
            is_pred      <= 1'b0;
            is_pred_pc   <= 32'd0;
            line_valid_q <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mc_req     <= mc_req_d;
            mc_addr    <= mc_addr_d;
            is_valid   <= is_valid_d;
            is_ins     <= is_ins_d;
            is_pc      <= is_pc_d;
            is_pred    <= is_pred_d;
            is_pred_pc <= is_pred_pc_d;
            if (fill_en) begin
                line_valid_q[pc_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && rdy && fill_en) begin
            line_tag_q[pc_idx]  <= pc_tag;
            line_data_q[pc_idx] <= mc_data;
        end
    end

endmodule
